// File: rtl/i2s_in.sv
// I2S slave receiver: oversamples sclk/lrclk/sdin in the clk domain and
// recovers left-justified signed L/R samples with a pair-valid strobe.
module i2s_in #(
    parameter int WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    lrclk,
    input  logic                    sdin,
    output logic signed [WIDTH-1:0] l_data,
    output logic signed [WIDTH-1:0] r_data,
    output logic                    valid,
    output logic                    short_word
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [2:0]       sclk_sync_q;
    logic [1:0]       lrclk_sync_q;
    logic [1:0]       sdin_sync_q;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             armed_q, armed_d;
    logic             lr_prev_q, lr_prev_d;
    logic             have_left_q, have_left_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             valid_q, valid_d;
    logic             short_q, short_d;

    logic             sample_e;
    logic             lr;
    logic             sd;
    logic [WIDTH-1:0] sr_app;
    logic [CW-1:0]    cnt_app;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] word;

    // lrclk and sdin take the same two stages as sclk, so all three line up at E
    assign sample_e = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign lr       = lrclk_sync_q[1];
    assign sd       = sdin_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdin_sync_q  <= '0;
            sr_q         <= '0;
            bitcnt_q     <= '0;
            armed_q      <= 1'b0;
            lr_prev_q    <= 1'b0;
            have_left_q  <= 1'b0;
            l_q          <= '0;
            r_q          <= '0;
            valid_q      <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
            lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
            sdin_sync_q  <= {sdin_sync_q[0], sdin};
            sr_q         <= sr_d;
            bitcnt_q     <= bitcnt_d;
            armed_q      <= armed_d;
            lr_prev_q    <= lr_prev_d;
            have_left_q  <= have_left_d;
            l_q          <= l_d;
            r_q          <= r_d;
            valid_q      <= valid_d;
            short_q      <= short_d;
        end
    end

    always_comb begin
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        armed_d     = armed_q;
        lr_prev_d   = lr_prev_q;
        have_left_d = have_left_q;
        l_d         = l_q;
        r_d         = r_q;
        valid_d     = 1'b0;
        short_d     = 1'b0;
        sr_app      = sr_q;
        cnt_app     = bitcnt_q;

        // bits past WIDTH in a long slot are dropped; the counter saturates
        if (bitcnt_q < FULL) begin
            sr_app  = {sr_q[WIDTH-2:0], sd};
            cnt_app = bitcnt_q + CW'(1);
        end
        shamt = FULL - cnt_app;
        word  = sr_app << shamt;

        if (sample_e) begin
            sr_d     = sr_app;
            bitcnt_d = cnt_app;
            if (lr != lr_prev_q) begin
                // the boundary bit still belongs to the slot that is closing
                if (armed_q) begin
                    if (!lr_prev_q) begin
                        l_d         = word;
                        have_left_d = 1'b1;
                    end else begin
                        r_d = word;
                        if (have_left_q) begin
                            valid_d     = 1'b1;
                            have_left_d = 1'b0;
                        end
                    end
                    short_d = (cnt_app < FULL);
                end
                sr_d      = '0;
                bitcnt_d  = '0;
                armed_d   = 1'b1;
                lr_prev_d = lr;
            end
        end
    end

    assign l_data     = l_q;
    assign r_data     = r_q;
    assign valid      = valid_q;
    assign short_word = short_q;

endmodule

// File: tb/tb_i2s_in.sv
// Self-checking bench for i2s_in: a slot-level reference model predicts the
// outputs cycle by cycle, plus literal checks of the recovered samples.
`timescale 1ns/1ps
module tb_i2s_in;
    localparam int W = 24;
    localparam int H = 3;   // clk cycles per sclk phase

    logic clk = 1'b0;
    logic reset;
    logic sclk = 1'b0, lrclk = 1'b0, sdin = 1'b0;
    logic [W-1:0] l_data, r_data;
    logic valid, short_word;

    i2s_in #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
        .l_data(l_data), .r_data(r_data), .valid(valid), .short_word(short_word)
    );

    always #31 clk = ~clk;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        int           due;
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         v;
        logic         s;
    } ev_t;
    ev_t evq[$];

    bit           mbits[$];
    logic         m_armed, m_lrp, m_hl;
    logic [W-1:0] m_l, m_r;
    logic [W-1:0] e_l, e_r;
    logic         e_v, e_s;

    int           nvalid, nshort;
    logic         got_first;
    logic [W-1:0] fv_l, fv_r, lv_l, lv_r;

    bit q_lr[$], q_sd[$];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        mbits.delete();
        evq.delete();
        m_armed = 1'b0; m_lrp = 1'b0; m_hl = 1'b0;
        m_l = '0; m_r = '0;
        e_l = '0; e_r = '0; e_v = 1'b0; e_s = 1'b0;
    endfunction

    // One sclk rising edge at the pins, seen by the model with the lrclk/sdin
    // levels it samples. Outputs are due 3 clk edges after the pin edge.
    function automatic void model_rise(input bit lr, input bit sd, input int c);
        ev_t ev;
        logic [W-1:0] word;
        int n;
        if (mbits.size() < W) mbits.push_back(sd);
        if (lr != m_lrp) begin
            n = mbits.size();
            word = '0;
            for (int i = 0; i < n; i++) if (mbits[i]) word[W-1-i] = 1'b1;
            ev.v = 1'b0;
            ev.s = 1'b0;
            if (m_armed) begin
                if (m_lrp == 1'b0) begin
                    m_l = word;
                    m_hl = 1'b1;
                end else begin
                    m_r = word;
                    if (m_hl) begin
                        ev.v = 1'b1;
                        m_hl = 1'b0;
                    end
                end
                ev.s = (n < W);
            end
            ev.due = c + 3;
            ev.l = m_l;
            ev.r = m_r;
            evq.push_back(ev);
            mbits.delete();
            m_armed = 1'b1;
            m_lrp = lr;
        end
    endfunction

    function automatic void add_slot(input bit lr_body, input bit lr_last,
                                     input logic [W-1:0] val, input int d, input int s, input bit pad);
        for (int i = 0; i < s; i++) begin
            q_sd.push_back((i < d) ? val[d-1-i] : pad);
            q_lr.push_back((i == s - 1) ? lr_last : lr_body);
        end
    endfunction

    function automatic void add_frame(input logic [W-1:0] lv, input logic [W-1:0] rv,
                                      input int d, input int s, input bit pad);
        add_slot(1'b0, 1'b1, lv, d, s, pad);
        add_slot(1'b1, 1'b0, rv, d, s, pad);
    endfunction

    task automatic play(input int rst_on, input int rst_off);
        for (int i = 0; i < q_lr.size(); i++) begin
            @(negedge clk);
            if (i == rst_on) begin
                reset = 1'b1;
                model_reset();
            end
            if (i == rst_off) reset = 1'b0;
            sclk = 1'b0;
            lrclk = q_lr[i];
            sdin = q_sd[i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            if (!reset) model_rise(q_lr[i], q_sd[i], cyc);
            repeat (H - 1) @(negedge clk);
        end
        @(negedge clk);
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        q_lr.delete();
        q_sd.delete();
    endtask

    task automatic clear_stats();
        nvalid = 0;
        nshort = 0;
        got_first = 1'b0;
    endtask

    task automatic check_pair(input string tag, input logic [W-1:0] lx, input logic [W-1:0] rx);
        check({tag, " model L"}, m_l, lx);
        check({tag, " model R"}, m_r, rx);
        check({tag, " pair L"}, lv_l, lx);
        check({tag, " pair R"}, lv_r, rx);
    endtask

    // per-cycle comparison against the model, one edge-delayed sample point
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            e_v = 1'b0;
            e_s = 1'b0;
            if (reset) begin
                e_l = '0;
                e_r = '0;
            end else begin
                while (evq.size() > 0 && evq[0].due <= cyc) begin
                    ev = evq.pop_front();
                    e_l = ev.l; e_r = ev.r; e_v = ev.v; e_s = ev.s;
                end
            end
            check("l_data", l_data, e_l);
            check("r_data", r_data, e_r);
            check("valid", W'(valid), W'(e_v));
            check("short_word", W'(short_word), W'(e_s));
            if (valid) begin
                nvalid++;
                lv_l = l_data;
                lv_r = r_data;
                if (!got_first) begin
                    got_first = 1'b1;
                    fv_l = l_data;
                    fv_r = r_data;
                end
            end
            if (short_word) nshort++;
        end
    end

    initial begin
        reset = 1'b0;
        model_reset();
        clear_stats();
        lv_l = '0; lv_r = '0; fv_l = '0; fv_r = '0;
        #2 reset = 1'b1;

        // 1: reset held with inputs toggling
        repeat (20) begin
            @(negedge clk);
            sclk  = 1'($urandom_range(0, 1));
            lrclk = 1'($urandom_range(0, 1));
            sdin  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
        check("t1 valid in reset", W'(nvalid), W'(0));
        check("t1 l_data in reset", l_data, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t1 l_data after release", l_data, '0);
        check("t1 r_data after release", r_data, '0);

        // 2: 32-bit slots with padding ones, lead frame plus three frames
        clear_stats();
        for (int f = 0; f < 4; f++) add_frame(24'h123456, 24'hABCDEF, 24, 32, 1'b1);
        play(-1, -1);
        check_pair("t2", 24'h123456, 24'hABCDEF);
        check("t2 valid count", W'(nvalid), W'(3));
        check("t2 short count", W'(nshort), W'(0));

        // 3: reset released in the middle of the first left slot
        clear_stats();
        for (int f = 0; f < 3; f++) add_frame(24'h000001, 24'hFFFFFF, 24, 32, 1'b0);
        play(0, 10);
        check("t3 first valid L", fv_l, 24'h000001);
        check("t3 first valid R", fv_r, 24'hFFFFFF);
        check("t3 valid count", W'(nvalid), W'(2));

        // 4: 16-bit slots, left-justified with zero fill
        clear_stats();
        for (int f = 0; f < 3; f++) add_frame(24'h00BEEF, 24'h008001, 16, 16, 1'b0);
        play(-1, -1);
        check_pair("t4", 24'hBEEF00, 24'h800100);
        check("t4 short count", W'(nshort), W'(6));
        check("t4 valid count", W'(nvalid), W'(3));

        // 5: slot exactly WIDTH, LSB sampled on the boundary edge
        clear_stats();
        for (int f = 0; f < 2; f++) add_frame(24'h800001, 24'h7FFFFE, 24, 24, 1'b0);
        play(-1, -1);
        check_pair("t5", 24'h800001, 24'h7FFFFE);
        check("t5 short count", W'(nshort), W'(0));
        check("t5 valid count", W'(nvalid), W'(2));

        // 6: reset pulse inside the first right slot
        clear_stats();
        for (int f = 0; f < 3; f++) add_frame(24'h00AA55, 24'h5500AA, 24, 32, 1'b0);
        play(42, 46);
        check_pair("t6", 24'h00AA55, 24'h5500AA);
        check("t6 valid count", W'(nvalid), W'(2));

        // 7: lrclk toggling on every bit, 1-bit slots of ones
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            q_lr.push_back((i % 2) == 0);
            q_sd.push_back(1'b1);
        end
        play(-1, -1);
        check_pair("t7", 24'h800000, 24'h800000);
        check("t7 short count", W'(nshort), W'(8));
        check("t7 valid count", W'(nvalid), W'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_in.md
Name: i2s_in

Overview:
- I2S receiver (deserializer), the input-side counterpart of the I2S serializer.
- Oversamples externally supplied sclk, lrclk and sdin in the system clock domain and recovers signed left/right samples.
- Presents each completed stereo pair with a one-cycle valid strobe for the audio processing path, such as ADC capture or loopback checking.
- sclk and lrclk are inputs; this block is an I2S slave.

Parameters:
- WIDTH, 24, sample width in bits. Also the maximum number of bits captured per channel slot.

Ports:
- clk  in  1  system clock (16 MHz); every register is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  I2S serial bit clock, asynchronous to clk.
- lrclk  in  1  I2S word clock; 0 = left, 1 = right.
- sdin  in  1  I2S serial data, MSB first.
- l_data  out  WIDTH  last received left sample, signed.
- r_data  out  WIDTH  last received right sample, signed.
- valid  out  1  one-clk pulse when a new L/R pair is on l_data/r_data.
- short_word  out  1  one-clk pulse when a committed slot held fewer than WIDTH bits.

Behaviour:
- Reset: asynchronous, active-high. Clears every register: synchronizers, shift register, bit counter, flags and all outputs. All outputs read 0 while reset is high.
- Synchronization: sclk, lrclk and sdin each pass through 2 flip-flops. A third sclk stage provides edge detection.
- Sample event E: asserted when sclk_s2=1 and sclk_s3=0. At E, lr = lrclk_s2 and sd = sdin_s2; both see equal sync delay.
- Clock ratio: each sclk high and low phase must last at least 2 clk periods. Behaviour is undefined otherwise.
- I2S timing: lrclk changes one bit before the MSB.
  - A boundary is an E where lr differs from lr_prev, the lr captured at the previous E.
  - The bit sampled at a boundary E belongs to the old channel.
- Every E:
  - If bitcnt < WIDTH: sr <= {sr[WIDTH-2:0], sd} and bitcnt++.
  - If bitcnt = WIDTH: the bit is discarded (slot longer than WIDTH).
- Boundary E, additionally:
  - word = sr after this E's append, left-justified. If n = bitcnt after the append is less than WIDTH, shift left by WIDTH-n and zero-fill the LSBs.
  - If armed = 1, commit word to the old channel: lr_prev=0 gives l_data, lr_prev=1 gives r_data.
  - If n < WIDTH, pulse short_word.
  - Then set bitcnt = 0, sr = 0, armed = 1, lr_prev = lr.
- armed: 0 after reset. The partial slot in progress when reset is released is discarded, with no commit and no short_word.
- Pair tracking:
  - A left commit sets have_left.
  - A right commit with have_left=1 pulses valid and clears have_left.
  - A right commit with have_left=0 updates r_data without pulsing valid.
- Latency:
  - l_data, r_data, valid and short_word update on the clk edge after the E cycle.
  - This is at most 4 clk after the boundary sclk rising edge at the pins.
  - Outputs hold between commits.
- A boundary at every E (1-bit slots) stays legal: n=1, the word is MSB-only and short_word pulses.
- lrclk constant forever: no commits. bitcnt saturates at WIDTH with no wrap.
- Reset asserted mid-word: the capture in progress is lost. After release, armed=0 again, so the first boundary only re-arms.

Test Plan:
1. Reset with toggling inputs -> l_data=r_data=0, valid=short_word=0 throughout reset and until the first committed pair.
2. WIDTH=24, 32-bit slots, L=24'h123456, R=24'hABCDEF, padding bits driven to 1, 3 frames -> l_data=24'h123456, r_data=24'hABCDEF. valid is a single-clk pulse once per frame, at most 4 clk after each right-to-left boundary. short_word never fires.
3. Reset released mid-left slot, then frames L=24'h000001 / R=24'hFFFFFF -> no valid for the partial frame. First valid carries 24'h000001 / 24'hFFFFFF.
4. 16-bit slots, L=16'hBEEF, R=16'h8001 -> l_data=24'hBEEF00, r_data=24'h800100. short_word pulses on each commit.
5. 24-bit slots (slot = WIDTH), L=24'h800001, R=24'h7FFFFE -> exact values captured, including the LSB sampled on the boundary edge. short_word=0.
6. Reset pulse in the middle of R bits, then normal frames L=24'h00AA55 / R=24'h5500AA -> outputs 0 during reset, no spurious valid, next full pair correct.
